// File: rtl/n_pipe_reg_pkg.sv
// Shared constants and helpers for the n_pipe_reg pipeline register.
// The occupancy width helper is used only when N_PIPE_REG_OCC_EN is defined.
package n_pipe_reg_pkg;

   // Default geometry of the pipeline.
   localparam int unsigned DefNBits   = 8;
   localparam int unsigned DefNStages = 4;

   // Width needed to count 0..n occupied stages.
   function automatic int unsigned occ_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/n_pipe_stage.sv
// One pipeline stage: an N_BITS data register plus its valid bit.
// Synchronous active-low reset loads {0, RESET_VAL}.
// en_i advances the stage and clr_i clears the valid bit.
// clr_i wins over a valid bit captured on the same edge.
// Data still follows en_i while clr_i is high.
module n_pipe_stage #(
   parameter int unsigned       N_BITS    = 8,
   parameter logic [N_BITS-1:0] RESET_VAL = '0
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic              valid_i,
   input  logic [N_BITS-1:0] d_i,
   output logic              valid_o,
   output logic [N_BITS-1:0] q_o
);

   logic              r_valid;
   logic [N_BITS-1:0] r_data;

   // Data register: loads on advance, otherwise holds. It ignores the valid bit.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_data <= RESET_VAL;
      end else if (en_i) begin
         r_data <= d_i;
      end
   end

   // Valid bit: a clear overrides both the capture and the hold.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_valid <= 1'b0;
      end else if (clr_i) begin
         r_valid <= 1'b0;
      end else if (en_i) begin
         r_valid <= valid_i;
      end
   end

   assign valid_o = r_valid;
   assign q_o     = r_data;

endmodule

// File: rtl/n_pipe_reg.sv
// n_pipe_reg: N_STAGES cascaded N_BITS-wide registers with per-stage valid bits.
// It supports a global stall (en_i), a synchronous flush of the valid bits and a
// programmable reset value.
// Outputs come straight from the last stage's registers.
// Optional feature macro: N_PIPE_REG_OCC_EN.
// When it is defined, the block adds a registered occupancy count, occ_o.
module n_pipe_reg
   import n_pipe_reg_pkg::*;
#(
   parameter int unsigned       N_BITS    = DefNBits,
   parameter int unsigned       N_STAGES  = DefNStages,
   parameter logic [N_BITS-1:0] RESET_VAL = '0
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              en_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [N_BITS-1:0] d_i,
   output logic              valid_o,
   output logic [N_BITS-1:0] q_o
`ifdef N_PIPE_REG_OCC_EN
   ,
   output logic [occ_width(N_STAGES)-1:0] occ_o
`endif
);

   // A zero-depth or zero-width pipeline is meaningless, so reject it at elaboration.
   if (N_STAGES < 1) begin : g_bad_stages
      $error("n_pipe_reg: N_STAGES must be >= 1");
   end
   if (N_BITS < 1) begin : g_bad_bits
      $error("n_pipe_reg: N_BITS must be >= 1");
   end

   logic [N_STAGES-1:0]             w_valid;
   logic [N_STAGES-1:0][N_BITS-1:0] w_data;

   for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      logic              w_vin;
      logic [N_BITS-1:0] w_din;

      if (k == 0) begin : g_head
         assign w_vin = valid_i;
         assign w_din = d_i;
      end else begin : g_body
         assign w_vin = w_valid[k-1];
         assign w_din = w_data[k-1];
      end

      n_pipe_stage #(
         .N_BITS    (N_BITS),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk_i    (clk_i),
         .reset_ni (reset_ni),
         .en_i     (en_i),
         .clr_i    (flush_i),
         .valid_i  (w_vin),
         .d_i      (w_din),
         .valid_o  (w_valid[k]),
         .q_o      (w_data[k])
      );
   end

   assign valid_o = w_valid[N_STAGES-1];
   assign q_o     = w_data[N_STAGES-1];

`ifdef N_PIPE_REG_OCC_EN
   localparam int unsigned OccW = occ_width(N_STAGES);

   logic [OccW-1:0] r_occ;
   logic [OccW-1:0] w_occ_d;

   // The count is tracked incrementally, which keeps it equal to the number of set valid bits.
   // On an advance it gains the entering valid bit and loses the one shifted out.
   // The true result always fits in OccW bits, so wrap-around in the intermediate sum is harmless.
   always_comb begin
      w_occ_d = r_occ;
      if (flush_i) begin
         w_occ_d = '0;
      end else if (en_i) begin
         w_occ_d = r_occ + OccW'(valid_i) - OccW'(w_valid[N_STAGES-1]);
      end
   end

   // Occupancy register; it updates on the same edge as the valid bits it counts.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_occ <= '0;
      end else begin
         r_occ <= w_occ_d;
      end
   end

   assign occ_o = r_occ;
`endif

endmodule

// File: tb/tb_n_pipe_reg.sv
// Directed self-checking bench for n_pipe_reg.
// dut:  N_STAGES=4, RESET_VAL=8'h00
// dut1: N_STAGES=1, RESET_VAL=8'hA5
// Both DUTs share all inputs.
module tb_n_pipe_reg;

   logic       clk_i    = 1'b0;
   logic       reset_ni = 1'b0;
   logic       en_i     = 1'b0;
   logic       flush_i  = 1'b0;
   logic       valid_i  = 1'b0;
   logic [7:0] d_i      = 8'h00;

   logic       valid_o;
   logic [7:0] q_o;
   logic       valid1_o;
   logic [7:0] q1_o;

   int n_cmp = 0;
   int n_mis = 0;

`ifdef N_PIPE_REG_OCC_EN
   logic [2:0] occ_o;
   logic [0:0] occ1_o;
`endif

   always #5 clk_i = ~clk_i;

   n_pipe_reg #(
      .N_BITS    (8),
      .N_STAGES  (4),
      .RESET_VAL (8'h00)
   ) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (en_i),
      .flush_i  (flush_i),
      .valid_i  (valid_i),
      .d_i      (d_i),
      .valid_o  (valid_o),
      .q_o      (q_o)
`ifdef N_PIPE_REG_OCC_EN
      ,
      .occ_o    (occ_o)
`endif
   );

   n_pipe_reg #(
      .N_BITS    (8),
      .N_STAGES  (1),
      .RESET_VAL (8'hA5)
   ) dut1 (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (en_i),
      .flush_i  (flush_i),
      .valid_i  (valid_i),
      .d_i      (d_i),
      .valid_o  (valid1_o),
      .q_o      (q1_o)
`ifdef N_PIPE_REG_OCC_EN
      ,
      .occ_o    (occ1_o)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge and settle before sampling.
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic en, input logic fl, input logic v, input logic [7:0] d);
      en_i    = en;
      flush_i = fl;
      valid_i = v;
      d_i     = d;
   endtask

   initial begin
      // Reset: inputs active, the outputs must still show the reset state.
      drive(1'b1, 1'b0, 1'b1, 8'hFF);
      reset_ni = 1'b0;
      cycle();
      cycle();
      check_eq("rst_valid", valid_o, 0);
      check_eq("rst_q", q_o, 8'h00);
      check_eq("rst_valid1", valid1_o, 0);
      check_eq("rst_q1_a5", q1_o, 8'hA5);
      reset_ni = 1'b1;

      // Latency: the first sample appears on the 4th enabled edge.
      drive(1'b1, 1'b0, 1'b1, 8'h01); cycle();
      check_eq("lat_e1_valid", valid_o, 0);
      check_eq("lat_single_q", q1_o, 8'h01);
      check_eq("lat_single_v", valid1_o, 1);
      drive(1'b1, 1'b0, 1'b1, 8'h02); cycle();
      check_eq("lat_e2_valid", valid_o, 0);
      drive(1'b1, 1'b0, 1'b1, 8'h03); cycle();
      check_eq("lat_e3_valid", valid_o, 0);
      drive(1'b1, 1'b0, 1'b0, 8'h00); cycle();
      check_eq("lat_e4_valid", valid_o, 1);
      check_eq("lat_e4_q", q_o, 8'h01);
      cycle();
      check_eq("lat_e5_q", q_o, 8'h02);
      check_eq("lat_e5_valid", valid_o, 1);
      cycle();
      check_eq("lat_e6_q", q_o, 8'h03);
      cycle();
      check_eq("lat_e7_valid", valid_o, 0);

      // Stall: two samples go in, then three hold cycles with junk on the inputs.
      drive(1'b1, 1'b0, 1'b1, 8'h10); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h11); cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'hEE); cycle();
         check_eq("stall_valid", valid_o, 0);
         check_eq("stall_hold_q1", q1_o, 8'h11);
         check_eq("stall_hold_v1", valid1_o, 1);
      end
      drive(1'b1, 1'b0, 1'b0, 8'h00); cycle();
      check_eq("stall_e3_valid", valid_o, 0);
      cycle();
      check_eq("stall_out0_valid", valid_o, 1);
      check_eq("stall_out0_q", q_o, 8'h10);
      cycle();
      check_eq("stall_out1_valid", valid_o, 1);
      check_eq("stall_out1_q", q_o, 8'h11);
      cycle();
      check_eq("stall_drain_valid", valid_o, 0);

      // Flush with en_i=1 and four samples in flight.
      drive(1'b1, 1'b0, 1'b1, 8'h21); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h22); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h23); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h24); cycle();
      check_eq("fl_full_valid", valid_o, 1);
      check_eq("fl_full_q", q_o, 8'h21);
      drive(1'b1, 1'b1, 1'b1, 8'h55); cycle();
      check_eq("fl_f0_valid", valid_o, 0);
      check_eq("fl_f0_q_shift", q_o, 8'h22);
      check_eq("fl_f0_valid1", valid1_o, 0);
      check_eq("fl_f0_q1", q1_o, 8'h55);
      drive(1'b1, 1'b0, 1'b1, 8'h66); cycle();
      check_eq("fl_f1_valid", valid_o, 0);
      drive(1'b1, 1'b0, 1'b1, 8'h67); cycle();
      check_eq("fl_f2_valid", valid_o, 0);
      drive(1'b1, 1'b0, 1'b0, 8'h00); cycle();
      check_eq("fl_f3_valid", valid_o, 0);
      cycle();
      check_eq("fl_new0_valid", valid_o, 1);
      check_eq("fl_new0_q", q_o, 8'h66);
      cycle();
      check_eq("fl_new1_q", q_o, 8'h67);
      cycle();
      check_eq("fl_new_drain", valid_o, 0);

      // Reset mid-stream with three samples in flight.
      drive(1'b1, 1'b0, 1'b1, 8'h31); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h32); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h33); cycle();
      reset_ni = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 8'h34); cycle();
      check_eq("mrst_valid", valid_o, 0);
      check_eq("mrst_q", q_o, 8'h00);
      check_eq("mrst_q1", q1_o, 8'hA5);
      reset_ni = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 8'h41); cycle();
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 2; i++) begin
         cycle();
         check_eq("mrst_lost_valid", valid_o, 0);
      end
      cycle();
      check_eq("mrst_new_valid", valid_o, 1);
      check_eq("mrst_new_q", q_o, 8'h41);
      cycle();
      check_eq("mrst_new_drain", valid_o, 0);

      // Flush while stalled: valid bits clear and the data holds.
      drive(1'b1, 1'b0, 1'b1, 8'h51); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h52); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h53); cycle();
      drive(1'b1, 1'b0, 1'b1, 8'h54); cycle();
      check_eq("flh_full_q", q_o, 8'h51);
      drive(1'b0, 1'b1, 1'b1, 8'h99); cycle();
      check_eq("flh_valid", valid_o, 0);
      check_eq("flh_q_held", q_o, 8'h51);
      check_eq("flh_q1_held", q1_o, 8'h54);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("flh_after_valid", valid_o, 0);
      end

`ifdef N_PIPE_REG_OCC_EN
      // Occupancy: two valid samples, then three invalid ones.
      reset_ni = 1'b0;
      cycle();
      reset_ni = 1'b1;
      check_eq("occ_rst", occ_o, 0);
      drive(1'b1, 1'b0, 1'b1, 8'h01); cycle(); check_eq("occ_1", occ_o, 1);
      drive(1'b1, 1'b0, 1'b1, 8'h02); cycle(); check_eq("occ_2", occ_o, 2);
      drive(1'b1, 1'b0, 1'b0, 8'h00); cycle(); check_eq("occ_3", occ_o, 2);
      cycle(); check_eq("occ_4", occ_o, 2);
      cycle(); check_eq("occ_5", occ_o, 1);
      cycle(); check_eq("occ_6", occ_o, 0);
      drive(1'b1, 1'b0, 1'b1, 8'h03); cycle();
      cycle(); check_eq("occ_pre_fl", occ_o, 2);
      drive(1'b1, 1'b1, 1'b1, 8'h04); cycle(); check_eq("occ_flush", occ_o, 0);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
